// File: rtl/mfp_gauss_conv1d.sv
// Streaming 1-D Gaussian convolver: valid-mode FIR over a line-based pixel stream,
// three-stage pipeline (window, products, rounded/saturated output) with a global stall.
module mfp_gauss_conv1d #(
  parameter int TAPS   = 11,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [COEF_W*TAPS-1:0]   coef,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic                     short_line
);

  localparam int PW = DATA_W + COEF_W + 1;
  localparam int AW = PW + $clog2(TAPS);
  localparam int CW = $clog2(TAPS + 1);
  localparam logic [CW-1:0]        TAPS_C  = CW'(TAPS);
  localparam logic signed [AW-1:0] RND     = AW'(2 ** (COEF_W - 2));
  localparam logic signed [AW-1:0] SAT_MAX = AW'((2 ** DATA_W) - 1);

  logic                     run_q, run_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     short_q, short_d;
  logic [DATA_W-1:0]        w_q [TAPS];
  logic [DATA_W-1:0]        w_d [TAPS];
  logic                     v0_q, v0_d, last0_q, last0_d;
  logic signed [PW-1:0]     p_q [TAPS];
  logic signed [PW-1:0]     p_d [TAPS];
  logic                     v1_q, v1_d, last1_q, last1_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;

  logic                     en;
  logic                     accept;
  logic                     launch;
  logic [CW-1:0]            cnt_inc;
  logic signed [AW-1:0]     acc;
  logic signed [AW-1:0]     rnd;
  logic [DATA_W-1:0]        sat;

  // run_q keeps in_ready low until the first edge with rst_n sampled high
  assign en        = !out_valid_q || out_ready;
  assign in_ready  = run_q && en;
  assign accept    = in_valid && in_ready;

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign short_line = short_q;

  always_comb begin
    run_d   = 1'b1;
    cnt_inc = (cnt_q == TAPS_C) ? TAPS_C : cnt_q + CW'(1);
    launch  = accept && (cnt_inc == TAPS_C);
    short_d = accept && in_last && (cnt_inc != TAPS_C);
    cnt_d   = cnt_q;
    if (accept) cnt_d = in_last ? '0 : cnt_inc;

    w_d = w_q;
    if (accept) begin
      w_d[0] = in_data;
      for (int i = 1; i < TAPS; i++) w_d[i] = w_q[i-1];
    end

    v0_d    = en ? launch : v0_q;
    last0_d = en ? (launch && in_last) : last0_q;
  end

  // coef[k] pairs with the oldest end of the window, w[TAPS-1-k]
  always_comb begin
    logic signed [PW-1:0] pix;
    logic signed [PW-1:0] cf;
    pix = '0;
    cf  = '0;
    for (int k = 0; k < TAPS; k++) begin
      pix    = PW'({1'b0, w_q[TAPS-1-k]});
      cf     = PW'($signed(coef[k*COEF_W +: COEF_W]));
      p_d[k] = en ? (pix * cf) : p_q[k];
    end
    v1_d    = en ? v0_q : v1_q;
    last1_d = en ? last0_q : last1_q;
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) acc = acc + AW'(p_q[k]);
    rnd = (acc + RND) >>> (COEF_W - 1);
    if (rnd < 0)             sat = '0;
    else if (rnd > SAT_MAX)  sat = '1;
    else                     sat = rnd[DATA_W-1:0];

    out_valid_d = en ? v1_q : out_valid_q;
    out_last_d  = en ? last1_q : out_last_q;
    out_data_d  = (en && v1_q) ? sat : out_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      cnt_q       <= '0;
      short_q     <= 1'b0;
      w_q         <= '{default: '0};
      v0_q        <= 1'b0;
      last0_q     <= 1'b0;
      p_q         <= '{default: '0};
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      run_q       <= run_d;
      cnt_q       <= cnt_d;
      short_q     <= short_d;
      w_q         <= w_d;
      v0_q        <= v0_d;
      last0_q     <= last0_d;
      p_q         <= p_d;
      v1_q        <= v1_d;
      last1_q     <= last1_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_mfp_gauss_conv1d.sv
// Scoreboard bench for mfp_gauss_conv1d: a driver feeds lines through a plain-arithmetic
// reference model, and an independent monitor checks every output the DUT presents.
module tb_mfp_gauss_conv1d;

  localparam int TAPS   = 5;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [COEF_W*TAPS-1:0] coef = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [DATA_W-1:0]      in_data = '0;
  logic                   in_last = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b1;
  logic [DATA_W-1:0]      out_data;
  logic                   out_last;
  logic                   short_line;

  mfp_gauss_conv1d #(.TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W)) dut (
    .clk(clk), .rst_n(rst_n), .coef(coef),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .short_line(short_line)
  );

  always #5 clk = ~clk;

  typedef struct { int data; bit last; int edge_n; } exp_t;

  exp_t exp_q[$];
  int   short_q[$];
  int   hist[$];
  int   cf[TAPS];
  int   act_d[$];
  bit   act_l[$];
  int   s1_d[$];
  bit   s1_l[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit in_rst = 1'b0;
  int last_lo_cyc = -1;
  int force_lo = 0;
  int ready_prob = 100;
  int n_out = 0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    in_rst <= !rst_n;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  task automatic loadCoef();
    for (int k = 0; k < TAPS; k++) coef[k*COEF_W +: COEF_W] = COEF_W'(cf[k]);
  endtask

  // Reference: the newest TAPS samples of the line, coef[0] on the oldest
  task automatic modelAccept(input int d, input bit last, input int e);
    longint acc;
    longint r;
    exp_t   x;
    hist.push_back(d);
    while (hist.size() > TAPS) void'(hist.pop_front());
    if (hist.size() == TAPS) begin
      acc = 0;
      for (int k = 0; k < TAPS; k++) acc += longint'(cf[k]) * longint'(hist[k]);
      r = (acc + (64'sd1 << (COEF_W - 2))) >>> (COEF_W - 1);
      if (r < 0) r = 0;
      else if (r > (2 ** DATA_W) - 1) r = (2 ** DATA_W) - 1;
      x.data = int'(r);
      x.last = last;
      x.edge_n = e;
      exp_q.push_back(x);
    end else if (last) begin
      short_q.push_back(e);
    end
    if (last) hist.delete();
  endtask

  task automatic driveReady();
    if (force_lo > 0) begin
      out_ready = 1'b0;
      force_lo--;
    end else begin
      out_ready = ($urandom_range(99) < ready_prob);
    end
    if (!out_ready) last_lo_cyc = cyc;
  endtask

  task automatic applyStimulus(input int d, input bit last);
    int tries = 0;
    bit done = 1'b0;
    while (!done) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DATA_W'(d);
      in_last  = last;
      driveReady();
      #1;
      if (in_ready === 1'b1) begin
        modelAccept(d, last, cyc + 1);
        done = 1'b1;
      end else if (++tries > 200) begin
        checkOutput("accept_timeout", 32'd0, 32'd1);
        done = 1'b1;
      end
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      driveReady();
    end
  endtask

  task automatic drain();
    int t = 0;
    forever begin
      @(negedge clk);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      #3;
      if (exp_q.size() == 0 && short_q.size() == 0) break;
      if (++t > 300) begin
        checkOutput("drain_timeout", exp_q.size() + short_q.size(), 32'd0);
        break;
      end
    end
    repeat (3) begin
      @(negedge clk);
      out_ready = 1'b1;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    exp_q.delete();
    short_q.delete();
    hist.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: samples mid-cycle, pops the scoreboard on each output handshake
  initial begin : monitor
    bit   hold_valid;
    int   hold_data;
    bit   hold_last;
    bit   exp_s;
    exp_t e;
    hold_valid = 1'b0;
    hold_data  = 0;
    hold_last  = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      #2;
      if (in_rst) begin
        checkOutput("rst_out_valid", out_valid, 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        checkOutput("rst_out_last", out_last, 32'd0);
        checkOutput("rst_short_line", short_line, 32'd0);
        checkOutput("rst_in_ready", in_ready, 32'd0);
        hold_valid = 1'b0;
      end else begin
        checkOutput("in_ready", in_ready, (!out_valid || out_ready) ? 32'd1 : 32'd0);
        exp_s = (short_q.size() > 0) && (short_q[0] == cyc);
        if (exp_s) void'(short_q.pop_front());
        if (exp_s || short_line !== 1'b0) checkOutput("short_line", short_line, exp_s);
        if (out_valid === 1'b1) begin
          if (hold_valid) begin
            checkOutput("hold_data", out_data, hold_data);
            checkOutput("hold_last", out_last, hold_last);
          end
          if (out_ready) begin
            hold_valid = 1'b0;
            if (exp_q.size() == 0) begin
              checkOutput("unexpected_output", out_data, 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              checkOutput("out_data", out_data, e.data);
              checkOutput("out_last", out_last, e.last);
              if (last_lo_cyc < e.edge_n) checkOutput("latency", cyc, e.edge_n + 2);
              n_out++;
              act_d.push_back(int'(out_data));
              act_l.push_back(out_last);
            end
          end else begin
            hold_valid = 1'b1;
            hold_data  = int'(out_data);
            hold_last  = out_last;
          end
        end else begin
          hold_valid = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    int base;
    int len;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Centre-tap delta
    cf = '{0, 0, 64, 0, 0};
    loadCoef();
    base = n_out;
    for (int i = 1; i <= 8; i++) applyStimulus(10 * i, i == 8);
    drain();
    checkOutput("s1_count", n_out - base, 32'd4);
    s1_d = act_d[base:$];
    s1_l = act_l[base:$];

    // Saturation high
    cf = '{127, 127, 127, 127, 127};
    loadCoef();
    for (int i = 0; i < 6; i++) applyStimulus(255, i == 5);
    drain();

    // Saturation low and rounding
    cf = '{0, 0, -64, 0, 0};
    loadCoef();
    for (int i = 0; i < 5; i++) applyStimulus(100, i == 4);
    drain();
    cf = '{0, 0, 1, 0, 0};
    loadCoef();
    for (int i = 0; i < 5; i++) applyStimulus(64, i == 4);
    for (int i = 0; i < 5; i++) applyStimulus(63, i == 4);
    drain();

    // Backpressure mid-stream
    cf = '{4, 16, 24, 16, 4};
    loadCoef();
    base = n_out;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) force_lo = 4;
      applyStimulus($urandom_range(255), i == 19);
    end
    drain();
    checkOutput("bp_count", n_out - base, 32'd16);

    // Short line followed immediately by a full line
    cf = '{0, 0, 64, 0, 0};
    loadCoef();
    base = n_out;
    for (int i = 0; i < 3; i++) applyStimulus(30 + i, i == 2);
    for (int i = 0; i < 5; i++) applyStimulus(100 + 10 * i, i == 4);
    drain();
    checkOutput("short_then_full_count", n_out - base, 32'd1);

    // Reset mid-line, then replay the delta line
    for (int i = 1; i <= 3; i++) applyStimulus(10 * i, 1'b0);
    doReset();
    base = n_out;
    for (int i = 1; i <= 8; i++) applyStimulus(10 * i, i == 8);
    drain();
    checkOutput("replay_count", n_out - base, s1_d.size());
    for (int i = 0; i < s1_d.size() && base + i < act_d.size(); i++) begin
      checkOutput("replay_data", act_d[base + i], s1_d[i]);
      checkOutput("replay_last", act_l[base + i], s1_l[i]);
    end

    // Randomized lines, coefficients and backpressure
    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < TAPS; k++) cf[k] = int'($urandom_range(255)) - 128;
      loadCoef();
      ready_prob = 40 + 10 * b;
      for (int l = 0; l < 8; l++) begin
        len = $urandom_range(12, 1);
        for (int i = 0; i < len; i++) begin
          applyStimulus($urandom_range(255), i == len - 1);
          if ($urandom_range(3) == 0) idleCycles($urandom_range(2, 1));
        end
      end
      drain();
      ready_prob = 100;
    end

    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mfp_gauss_conv1d.md
# mfp_gauss_conv1d

Streaming 1-D Gaussian convolver that consumes the packed signed fixed-point coefficient vector produced by the team's Gaussian table generators, `MFP_gaussianTableArr` (bit-compatible with `MFP_real` encoding). It applies that vector to a line-based pixel stream. It is the consumer end of the coefficient-table interface and sits in the SIFT scale-space path, where two instances (row and column) form a separable blur. Outputs use "valid" convolution: one result per full window, no border padding.

## Interface
- `TAPS`, 11: kernel length; odd, 3..31.
- `DATA_W`, 8: unsigned pixel width, for both input and output.
- `COEF_W`, 8: coefficient width; signed, value = code / 2^(COEF_W-1).
- `clk` input 1: clock.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `coef` input COEF_W*TAPS: coefficient k occupies bits `[k*COEF_W +: COEF_W]`. Must be static while any line is in flight.
- `in_valid` input 1: input sample is present.
- `in_ready` output 1: block can accept a sample this cycle.
- `in_data` input DATA_W: unsigned pixel.
- `in_last` input 1: marks the final sample of a line.
- `out_valid` output 1: result is present.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output DATA_W: rounded, saturated result.
- `out_last` output 1: marks the final result of a line.
- `short_line` output 1: one-cycle pulse when a line shorter than TAPS ends.

## Operation
- **Accept:** a sample is accepted on a rising edge where `in_valid && in_ready`.
- **Window:** TAPS-deep shift register. `w[0]` is the newest sample and `w[TAPS-1]` the oldest. It shifts only on accept.
- **Line counter `cnt`:** range 0..TAPS.
  - On accept, `cnt` increments, saturating at TAPS.
  - If the accepted sample has `in_last`, `cnt` returns to 0 after this sample is evaluated.
  - Stale window contents are never used, because a result is only issued when `cnt` reaches TAPS.
- **Window-full condition:** the sample that brings `cnt` (including itself) to at least TAPS launches a result into the pipeline. That result's `last` flag is the sample's `in_last`.
- **Arithmetic:**
  - acc = Σ_{k=0}^{TAPS-1} coef[k] · w[TAPS-1-k]. Coefficient 0 pairs with the oldest sample (the xstart side of the table).
  - Each product is signed, DATA_W+COEF_W+1 bits.
  - acc width is DATA_W+COEF_W+1+ceil(log2 TAPS). acc never overflows.
  - Rounding: r = (acc + 2^(COEF_W-2)) >>> (COEF_W-1), using an arithmetic shift (round half up).
  - Saturation: r < 0 gives 0; r > 2^DATA_W-1 gives 2^DATA_W-1.
- **Short line:** if `in_last` is accepted while `cnt` (including that sample) is below TAPS:
  - no result and no `out_last` are produced;
  - `short_line` pulses high for exactly the cycle after the accepting edge. This pulse is independent of backpressure.
- **Pipeline:** three register stages, each with its own valid bit.
  - S0: window and launch flag.
  - S1: registered products.
  - S2: output register holding `out_data`, `out_valid` and `out_last`.
- **Stall:** global enable `en = !out_valid || out_ready`. When `en` is 0, every stage holds its contents. `in_ready = en`.
- **Reset while `rst_n` is low:**
  - window, products, all valid bits, `cnt`, `out_data`, `out_last` and `short_line` are set to 0;
  - `out_valid` = 0 and `in_ready` = 0;
  - any line in progress is discarded, and the first sample accepted after reset starts a new line.

## Timing
- **Latency:** a window-completing sample accepted on edge E produces a result visible after edge E+2, provided `en` was 1 on edges E+1 and E+2.
- **Throughput:** one sample per cycle while `out_ready` stays high.
- **Output stability:** while `out_valid && !out_ready`, `out_data` and `out_last` hold constant and `in_ready` = 0 in the same cycle (combinational from `out_valid`/`out_ready`).
- **Combinational path:** `in_ready` depends only on registered `out_valid` and the `out_ready` input. There is no path from `in_valid` to `in_ready`.
- **Release from reset:** `in_ready` goes to 1 in the first cycle after the edge on which `rst_n` is sampled high.
- **Back-to-back lines:** an `in_last` sample followed immediately by the next line's first sample needs no bubble.
- **Ordering:** results leave in acceptance order, with no loss and no duplication under any `out_ready` pattern.

## Test plan
1. **Centre-tap delta.** TAPS=5, DATA_W=8, COEF_W=8, coef = {0,0,64,0,0}. Send line 10,20,…,80 with `in_last` on 80 and `out_ready`=1.
   - Required: outputs 15, 20, 25, 30; `out_last` only on 30.
   - Required: first `out_valid` appears 2 cycles after the 5th sample is accepted.
2. **Saturation high.** coef all 127, every input 255.
   - Required: acc = 161925 and `out_data` = 255.
3. **Saturation low and rounding.**
   - Centre coef -64, input 100: `out_data` = 0.
   - Centre coef 1, input 64: `out_data` = 1.
   - Centre coef 1, input 63: `out_data` = 0.
4. **Backpressure.** Stream 20 samples and hold `out_ready` low for 4 cycles mid-stream.
   - Required: `in_ready` = 0 during the stall and `out_data` is held.
   - Required: the output sequence matches a golden model exactly (16 results for TAPS=5).
5. **Short line, then full line.** Send 3 samples with `in_last` (TAPS=5), followed immediately by a 5-sample line.
   - Required: a single `short_line` pulse one cycle after the 3rd sample is accepted.
   - Required: exactly one result from the second line, with `out_last`=1.
6. **Reset mid-line.** Assert `rst_n`=0 for one edge after 3 of the samples from scenario 1, then replay scenario 1.
   - Required: all outputs are 0 during reset.
   - Required: the replay matches scenario 1 exactly.
